// File: rtl/ccip_rd_pkg.sv
// Shared types for the CCI-P C0 ring reader: FSM states, a minimal CCI-P C0
// channel view, the ROB tag-width helper and the RDLINE header builder.
package ccip_rd_pkg;

  localparam int unsigned CL_BYTES  = 64;
  localparam int unsigned CL_ADDR_W = 64 - $clog2(CL_BYTES);
  localparam int unsigned MDATA_W   = 16;

  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [MDATA_W-1:0]   t_ccip_mdata;
  typedef logic [511:0]         t_ccip_clData;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} t_rd_state;

  typedef enum logic [1:0] {eVC_VA = 2'd0, eVC_VL0 = 2'd1, eVC_VH0 = 2'd2, eVC_VH1 = 2'd3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'd0, eCL_LEN_2 = 2'd1, eCL_LEN_4 = 2'd3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  // Tag width for a reorder buffer of the given depth (at least one bit).
  function automatic int unsigned ROB_TAG_W(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Single-line RDLINE_I request on the auto-selected virtual channel.
  function automatic t_ccip_c0_ReqMemHdr mk_rdline_hdr(input t_ccip_clAddr addr,
                                                       input t_ccip_mdata  tag);
    t_ccip_c0_ReqMemHdr h;
    h          = '0;
    h.vc_sel   = eVC_VA;
    h.cl_len   = eCL_LEN_1;
    h.req_type = eREQ_RDLINE_I;
    h.address  = addr;
    h.mdata    = tag;
    return h;
  endfunction

endpackage

// File: rtl/ccip_rd_rob.sv
// Tag-indexed reorder buffer: tags are allocated in request order, filled in
// any order by read responses, and retired strictly in allocation order.
module ccip_rd_rob
  import ccip_rd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = ROB_TAG_W(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [511:0]     fill_data,
  output logic             fill_ok,
  input  logic             pop,
  output logic             out_valid,
  output logic [511:0]     out_data,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] slot_alloc;
  logic [DEPTH-1:0] slot_valid;
  logic [TAG_W-1:0] alloc_ptr;
  logic [TAG_W-1:0] ret_ptr;
  logic [TAG_W:0]   count;
  logic [511:0]     mem [DEPTH];
  logic             alloc_en;
  logic             fill_en;
  logic             pop_en;

  assign alloc_tag = alloc_ptr;
  assign full      = (count == (TAG_W+1)'(DEPTH));
  assign empty     = (count == '0);
  // A tag accepts data only while it is in flight and not yet filled.
  assign fill_ok   = slot_alloc[fill_tag] && !slot_valid[fill_tag];
  assign alloc_en  = alloc && !full;
  assign fill_en   = fill && fill_ok;
  assign pop_en    = pop && slot_valid[ret_ptr];
  assign out_valid = slot_valid[ret_ptr];
  assign out_data  = mem[ret_ptr];

  // Slot bookkeeping: allocation, fill and retirement may all occur together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_alloc <= '0;
      slot_valid <= '0;
      alloc_ptr  <= '0;
      ret_ptr    <= '0;
      count      <= '0;
    end else begin
      if (alloc_en) begin
        slot_alloc[alloc_ptr] <= 1'b1;
        alloc_ptr             <= alloc_ptr + 1'b1;
      end
      if (fill_en) begin
        slot_valid[fill_tag] <= 1'b1;
      end
      if (pop_en) begin
        slot_alloc[ret_ptr] <= 1'b0;
        slot_valid[ret_ptr] <= 1'b0;
        ret_ptr             <= ret_ptr + 1'b1;
      end
      count <= count + (TAG_W+1)'(alloc_en) - (TAG_W+1)'(pop_en);
    end
  end

  // Line storage; contents are qualified by slot_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_tag] <= fill_data;
    end
  end

endmodule

// File: rtl/ccip_ring_reader.sv
// CCI-P C0 ring reader: issues RDLINE_I reads for ring lines between the
// retire index and the producer tail, reorders the responses and hands the
// lines to a valid/ready consumer. Define CCIP_RD_STATS_EN to add the
// saturating request and stall counters.
module ccip_ring_reader
  import ccip_rd_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = 8,
  parameter int unsigned IDX_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [63:0]          setRd_addr,
  input  logic [IDX_W-1:0]     ring_lines,
  input  logic [IDX_W-1:0]     tail_idx,
  input  t_if_ccip_c0_Rx       c0_sRx,
  input  logic                 c0TxAlmFull,
  output t_if_ccip_c0_Tx       c0_sTx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [511:0]         out_data,
  output logic [IDX_W-1:0]     head_idx,
  output logic                 busy,
  output logic                 err_tag
`ifdef CCIP_RD_STATS_EN
  ,
  output logic [31:0]          stat_reqs,
  output logic [31:0]          stat_stall
`endif
);

  localparam int unsigned TAG_W = ROB_TAG_W(ROB_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  t_rd_state        state, state_nxt;
  t_ccip_clAddr     base_q;
  logic [IDX_W-1:0] size_q;
  logic [IDX_W-1:0] rd_idx;
  logic             pending;
  logic             issue;
  logic             rsp_hit;
  logic             upper_ok;
  logic             fill;
  logic             fill_ok;
  logic             tag_err;
  logic             pop;
  logic             rob_full;
  logic             rob_empty;
  logic [TAG_W-1:0] alloc_tag;
  logic             unused_bits;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x,
                                                input logic [IDX_W-1:0] size);
    return (x == size - IDX_ONE) ? '0 : x + IDX_ONE;
  endfunction

  assign pending  = (rd_idx != tail_idx) && (tail_idx < size_q);
  assign issue    = (state == RUN) && pending && !rob_full && !c0TxAlmFull;
  assign rsp_hit  = c0_sRx.rspValid && (c0_sRx.hdr.resp_type == eRSP_RDLINE);
  assign upper_ok = ((c0_sRx.hdr.mdata >> TAG_W) == '0);
  assign fill     = rsp_hit && upper_ok;
  assign tag_err  = rsp_hit && !(upper_ok && fill_ok);
  assign pop      = out_valid && out_ready;
  assign busy     = (state != IDLE);
  assign unused_bits = ^{setRd_addr[5:0], c0_sRx};

  ccip_rd_rob #(
    .DEPTH (ROB_DEPTH),
    .TAG_W (TAG_W)
  ) u_rob (
    .clk       (clk),
    .rst       (rst),
    .alloc     (issue),
    .alloc_tag (alloc_tag),
    .fill      (fill),
    .fill_tag  (c0_sRx.hdr.mdata[TAG_W-1:0]),
    .fill_data (c0_sRx.data),
    .fill_ok   (fill_ok),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (rob_full),
    .empty     (rob_empty)
  );

  // Run-state transitions.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable && (ring_lines != '0)) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (rob_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, ring configuration latch and read/retire indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      size_q   <= '0;
      rd_idx   <= '0;
      head_idx <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (state_nxt == RUN)) begin
        base_q <= setRd_addr[63:6];
        size_q <= ring_lines;
        rd_idx <= head_idx;
      end else if (issue) begin
        rd_idx <= wrap_inc(rd_idx, size_q);
      end
      if (pop) begin
        head_idx <= wrap_inc(head_idx, size_q);
      end
    end
  end

  // Registered C0 request; the header holds its last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_sTx <= '0;
    end else begin
      c0_sTx.valid <= issue;
      if (issue) begin
        c0_sTx.hdr <= mk_rdline_hdr(base_q + t_ccip_clAddr'(rd_idx), t_ccip_mdata'(alloc_tag));
      end
    end
  end

  // Sticky flag for responses that match no in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_tag <= 1'b0;
    end else if (tag_err) begin
      err_tag <= 1'b1;
    end
  end

`ifdef CCIP_RD_STATS_EN
  // Saturating issue and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reqs  <= '0;
      stat_stall <= '0;
    end else begin
      if (issue && (stat_reqs != '1)) begin
        stat_reqs <= stat_reqs + 32'd1;
      end
      if ((state == RUN) && (rd_idx != tail_idx) && (c0TxAlmFull || rob_full)
          && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ccip_ring_reader.sv
// Self-checking bench for ccip_ring_reader: a host model answers C0 reads,
// expected requests and lines are queued when each run is set up and checked
// as the DUT emits them.
module tb_ccip_ring_reader;
  import ccip_rd_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0012_3400_0000;

  typedef struct {
    int unsigned ring;
    int unsigned tail;
    bit          rev;
    int unsigned n;
    int unsigned first;
    int unsigned head_end;
  } vec_t;

  typedef struct {
    logic [57:0] addr;
    logic [15:0] mdata;
  } req_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [63:0]    setRd_addr;
  logic [15:0]    ring_lines;
  logic [15:0]    tail_idx;
  t_if_ccip_c0_Rx c0_sRx;
  logic           c0TxAlmFull;
  t_if_ccip_c0_Tx c0_sTx;
  logic           out_valid;
  logic           out_ready;
  logic [511:0]   out_data;
  logic [15:0]    head_idx;
  logic           busy;
  logic           err_tag;
`ifdef CCIP_RD_STATS_EN
  logic [31:0]    stat_reqs;
  logic [31:0]    stat_stall;
`endif

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  int unsigned  req_total = 0;
  int unsigned  exp_tag = 0;
  logic [57:0]  base_line;
  req_t         host_q[$];
  req_t         exp_req_q[$];
  logic [511:0] exp_out_q[$];
  req_t         mon_r, mon_e;
  logic [511:0] mon_d;
  vec_t         tbl[4];

  assign base_line = BASE[63:6];

  always #5 clk = ~clk;

  ccip_ring_reader #(
    .ROB_DEPTH (8),
    .IDX_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .setRd_addr  (setRd_addr),
    .ring_lines  (ring_lines),
    .tail_idx    (tail_idx),
    .c0_sRx      (c0_sRx),
    .c0TxAlmFull (c0TxAlmFull),
    .c0_sTx      (c0_sTx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .head_idx    (head_idx),
    .busy        (busy),
    .err_tag     (err_tag)
`ifdef CCIP_RD_STATS_EN
    ,
    .stat_reqs   (stat_reqs),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [511:0] pattern(input logic [57:0] addr);
    return {8{6'h2a, addr}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host/consumer monitor: checks each request and each retired line.
  always @(negedge clk) begin
    if (!rst) begin
      if (c0_sTx.valid) begin
        mon_r.addr  = c0_sTx.hdr.address;
        mon_r.mdata = c0_sTx.hdr.mdata;
        host_q.push_back(mon_r);
        req_total++;
        chk("req_expected", 512'(exp_req_q.size() != 0), 512'(1));
        if (exp_req_q.size() != 0) begin
          mon_e = exp_req_q.pop_front();
          chk("req_addr", 512'(mon_r.addr), 512'(mon_e.addr));
          chk("req_tag", 512'(mon_r.mdata), 512'(mon_e.mdata));
          chk("req_kind", 512'({c0_sTx.hdr.req_type, c0_sTx.hdr.vc_sel, c0_sTx.hdr.cl_len}),
              512'({eREQ_RDLINE_I, eVC_VA, eCL_LEN_1}));
        end
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 512'(exp_out_q.size() != 0), 512'(1));
        if (exp_out_q.size() != 0) begin
          mon_d = exp_out_q.pop_front();
          chk("out_data", out_data, mon_d);
        end
      end
    end
  end

  task automatic push_reads(input int unsigned ring, input int unsigned first,
                            input int unsigned n, input bit with_out);
    req_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e.addr  = base_line + 58'((first + k) % ring);
      e.mdata = 16'(exp_tag);
      exp_req_q.push_back(e);
      if (with_out) exp_out_q.push_back(pattern(e.addr));
      exp_tag = (exp_tag + 1) % 8;
    end
  endtask

  task automatic wait_reqs(input int unsigned n);
    int unsigned c = 0;
    while (host_q.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic wait_idle();
    int unsigned c = 0;
    while (busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("busy_idle", 512'(busy), 512'(0));
  endtask

  task automatic respond(input bit rev, input int unsigned n);
    req_t r;
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (rev && k > 0) chk("hold_until_head", 512'(out_valid), 512'(0));
      if (host_q.size() != 0) begin
        r = rev ? host_q.pop_back() : host_q.pop_front();
        c0_sRx               = '0;
        c0_sRx.rspValid      = 1'b1;
        c0_sRx.hdr.resp_type = eRSP_RDLINE;
        c0_sRx.hdr.mdata     = r.mdata;
        c0_sRx.data          = pattern(r.addr);
      end
    end
    @(negedge clk);
    c0_sRx = '0;
  endtask

  task automatic run_ring(input vec_t v);
    ring_lines = 16'(v.ring);
    tail_idx   = 16'(v.tail);
    out_ready  = 1'b1;
    push_reads(v.ring, v.first, v.n, 1'b1);
    @(negedge clk);
    enable = 1'b1;
    wait_reqs(v.n);
    repeat (10) @(negedge clk);
    chk("req_count", 512'(host_q.size()), 512'(v.n));
    respond(v.rev, v.n);
    @(negedge clk);
    enable = 1'b0;
    wait_idle();
    chk("head_idx", 512'(head_idx), 512'(v.head_end));
    chk("lines_left", 512'(exp_out_q.size()), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r0;
    tbl[0] = '{ring: 16, tail: 4,  rev: 1'b0, n: 4, first: 0,  head_end: 4};
    tbl[1] = '{ring: 16, tail: 12, rev: 1'b1, n: 8, first: 4,  head_end: 12};
    tbl[2] = '{ring: 16, tail: 2,  rev: 1'b0, n: 6, first: 12, head_end: 2};
    tbl[3] = '{ring: 4,  tail: 1,  rev: 1'b0, n: 3, first: 2,  head_end: 1};

    rst = 1'b1; enable = 1'b0; setRd_addr = BASE; ring_lines = '0; tail_idx = '0;
    c0_sRx = '0; c0TxAlmFull = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 512'(c0_sTx.valid), 512'(0));
    chk("rst_tx_hdr", 512'(c0_sTx.hdr), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_head", 512'(head_idx), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_err", 512'(err_tag), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // In-order, reversed, wrapping and small-ring runs.
    for (int i = 0; i < 4; i++) run_ring(tbl[i]);

    // Almost-full hold with a stalled consumer, then ROB-full stall.
    out_ready = 1'b0; c0TxAlmFull = 1'b1; ring_lines = 16'd16; tail_idx = 16'd13;
    push_reads(16, 1, 12, 1'b1);
    r0 = req_total;
    @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("almfull_hold", 512'(req_total - r0), 512'(0));
    chk("almfull_busy", 512'(busy), 512'(1));
    c0TxAlmFull = 1'b0;
    wait_reqs(8);
    repeat (10) @(negedge clk);
    chk("rob_full_stall", 512'(host_q.size()), 512'(8));
    respond(1'b0, 8);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 512'(out_valid), 512'(1));
      chk("stall_data", out_data, exp_out_q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_reqs(4);
    repeat (3) @(negedge clk);
    chk("req_count_tail", 512'(host_q.size()), 512'(4));
    respond(1'b0, 4);
    @(negedge clk);
    enable = 1'b0;
    wait_idle();
    chk("head_after_stall", 512'(head_idx), 512'(13));
    chk("err_clean", 512'(err_tag), 512'(0));

    // Tail beyond the ring size: nothing may be issued.
    r0 = req_total; ring_lines = 16'd16; tail_idx = 16'd20;
    @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    chk("tail_illegal", 512'(req_total - r0), 512'(0));
    enable = 1'b0;
    wait_idle();

    // Non-RDLINE response is ignored; a stray RDLINE tag while idle is flagged.
    @(negedge clk);
    c0_sRx = '0; c0_sRx.rspValid = 1'b1; c0_sRx.hdr.resp_type = eRSP_UMSG; c0_sRx.hdr.mdata = 16'd5;
    @(negedge clk);
    c0_sRx = '0;
    repeat (2) @(negedge clk);
    chk("umsg_ignored", 512'(err_tag), 512'(0));
    c0_sRx.rspValid = 1'b1; c0_sRx.hdr.resp_type = eRSP_RDLINE; c0_sRx.hdr.mdata = 16'd5;
    @(negedge clk);
    c0_sRx = '0;
    repeat (2) @(negedge clk);
    chk("stray_err", 512'(err_tag), 512'(1));
    chk("stray_no_out", 512'(out_valid), 512'(0));

    // Reset with three reads in flight.
    ring_lines = 16'd16; tail_idx = 16'd0;
    push_reads(16, 13, 3, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wait_reqs(3);
    chk("pre_rst_reqs", 512'(host_q.size()), 512'(3));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 512'(busy), 512'(0));
    chk("arst_tx_valid", 512'(c0_sTx.valid), 512'(0));
    chk("arst_out_valid", 512'(out_valid), 512'(0));
    chk("arst_head", 512'(head_idx), 512'(0));
    chk("arst_err", 512'(err_tag), 512'(0));
    enable = 1'b0;
    exp_req_q.delete();
    exp_out_q.delete();
    exp_tag = 0;
    @(negedge clk);
    rst = 1'b0;
    respond(1'b0, 3);
    repeat (2) @(negedge clk);
    chk("late_rsp_err", 512'(err_tag), 512'(1));
    chk("late_rsp_no_out", 512'(out_valid), 512'(0));
    run_ring('{ring: 16, tail: 2, rev: 1'b0, n: 2, first: 0, head_end: 2});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
